// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the triplet FIFO scheduler.
package fifo_sched_pkg;

    // Controller states: normal run, drain reads, zero-pad a partial triplet, flush complete.
    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        PAD,
        DONE
    } sched_state_t;

    // Words per consumer read (48-bit read port over 16-bit words).
    localparam int unsigned TRIPLET = 3;

    // Fill value for partial-triplet padding; wide enough for any supported word width.
    localparam logic [63:0] PAD_WORD = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority rotates past the last accepted winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0] last_grant_q;
    logic [IdxW-1:0] last_grant_d;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] cand;
    logic            found;

    // Search requesters starting one past the last winner, wrapping modulo N.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_q;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
        last_grant_d = advance ? grant_idx : last_grant_q;
    end

    // Last winner register; reset to N-1 so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            last_grant_q <= IdxW'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/fifo_triplet_sched.sv
// Write arbitration, occupancy tracking and triplet read sequencing for a 16-in/48-out FIFO.
module fifo_triplet_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [WIDTH-1:0]                fifo_din,
    output logic                            fifo_input_valid,
    input  logic                            fifo_input_ready,
    output logic                            fifo_output_ready,
    output logic                            cons_valid,
    input  logic                            cons_ready,
    input  logic                            flush_in,
    output logic                            flush_done,
    output logic [$clog2(DEPTH):0]          occupancy
);

    localparam int unsigned OccW = $clog2(DEPTH) + 1;
    localparam logic [OccW-1:0] OccMax  = OccW'(DEPTH);
    localparam logic [OccW-1:0] OccTrip = OccW'(TRIPLET);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [OccW-1:0]    occ_q;
    logic [OccW-1:0]    occ_d;
    logic [NUM_REQ-1:0] grant;
    logic               can_write;
    logic               wr_fire;
    logic               rd_fire;
    logic               grant_taken;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst_in (rst_in),
        .req    (req_valid),
        .advance(grant_taken),
        .grant  (grant)
    );

    // Handshake outputs; everything is held low while reset is asserted.
    always_comb begin
        can_write        = fifo_input_ready && (occ_q < OccMax);
        req_ready        = '0;
        fifo_din         = WIDTH'(PAD_WORD);
        fifo_input_valid = 1'b0;
        if (!rst_in && state_q == RUN && can_write) begin
            req_ready = grant;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                fifo_din = req_data[i];
            end
        end
        grant_taken = |req_ready;
        // Pad writes carry PAD_WORD, already the default on fifo_din.
        fifo_input_valid = grant_taken ||
                           (!rst_in && state_q == PAD && can_write && occ_q < OccTrip);
        cons_valid        = !rst_in && (occ_q >= OccTrip) &&
                            (state_q == RUN || state_q == DRAIN);
        fifo_output_ready = cons_valid && cons_ready;
        flush_done        = !rst_in && state_q == DONE;
        wr_fire           = fifo_input_valid && fifo_input_ready;
        rd_fire           = fifo_output_ready;
        occupancy         = occ_q;
    end

    // Occupancy next-state: +1 per word written, -3 per triplet read.
    always_comb begin
        occ_d = occ_q;
        case ({wr_fire, rd_fire})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccTrip;
            2'b11:   occ_d = occ_q - OccTrip + OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Flush sequencing: drain whole triplets, pad a residue of 1-2 words, then pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (occ_q == '0) begin
                    state_d = DONE;
                end else if (occ_q < OccTrip && !rd_fire) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                // Leave as soon as the write completing the triplet is accepted.
                if (occ_q >= OccTrip || (wr_fire && occ_q == OccTrip - OccW'(1))) begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= RUN;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    occ_no_overflow: assert property (@(posedge clk) disable iff (rst_in)
        !(wr_fire && !rd_fire && occ_q >= OccMax));

    occ_no_underflow: assert property (@(posedge clk) disable iff (rst_in)
        !(rd_fire && occ_q < OccTrip));

    ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_triplet_sched.sv
// Directed bench for fifo_triplet_sched with a small word-queue model of the FIFO.
module tb_fifo_triplet_sched;

    logic             clk;
    logic             rst_in;
    logic [3:0][15:0] req_data;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [15:0]      fifo_din;
    logic             fifo_input_valid;
    logic             fifo_input_ready;
    logic             fifo_output_ready;
    logic             cons_valid;
    logic             cons_ready;
    logic             flush_in;
    logic             flush_done;
    logic [7:0]       occupancy;

    int               checks = 0;
    int               errors = 0;
    int               pulses = 0;
    int               p0;
    logic [15:0]      q[$];
    logic [15:0]      w0, w1, w2;
    logic [47:0]      last_trip = '0;

    fifo_triplet_sched #(
        .WIDTH  (16),
        .DEPTH  (128),
        .NUM_REQ(4)
    ) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .req_data         (req_data),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .fifo_din         (fifo_din),
        .fifo_input_valid (fifo_input_valid),
        .fifo_input_ready (fifo_input_ready),
        .fifo_output_ready(fifo_output_ready),
        .cons_valid       (cons_valid),
        .cons_ready       (cons_ready),
        .flush_in         (flush_in),
        .flush_done       (flush_done),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO word model: newest word lands in the top slice of the read triplet.
    always @(posedge clk) begin
        if (rst_in) begin
            q.delete();
        end else begin
            if (fifo_output_ready && q.size() >= 3) begin
                w0 = q.pop_front();
                w1 = q.pop_front();
                w2 = q.pop_front();
                last_trip = {w2, w1, w0};
            end
            if (fifo_input_valid && fifo_input_ready) q.push_back(fifo_din);
        end
        if (flush_done) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in           = 1'b1;
        req_valid        = 4'hF;
        req_data         = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        fifo_input_ready = 1'b1;
        cons_ready       = 1'b0;
        flush_in         = 1'b0;
        tick();
        tick();

        // Reset: all outputs low even with every requester asking.
        chk("rst_req_ready", 48'(req_ready), 48'h0);
        chk("rst_in_valid", 48'(fifo_input_valid), 48'h0);
        chk("rst_out_ready", 48'(fifo_output_ready), 48'h0);
        chk("rst_cons_valid", 48'(cons_valid), 48'h0);
        chk("rst_flush_done", 48'(flush_done), 48'h0);
        chk("rst_occupancy", 48'(occupancy), 48'h0);
        chk("rst_din", 48'(fifo_din), 48'h0);

        // Fairness: grants rotate 0,1,2,3,0,1,2,3 from the first cycle out of reset.
        rst_in = 1'b0;
        #1;
        chk("first_din", 48'(fifo_din), 48'h1111);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_grant_%0d", i), 48'(req_ready), 48'(4'b0001 << (i % 4)));
            tick();
        end
        chk("rr_occ", 48'(occupancy), 48'd8);
        fifo_input_ready = 1'b0;
        #1;
        chk("stall_req_ready", 48'(req_ready), 48'h0);
        chk("stall_in_valid", 48'(fifo_input_valid), 48'h0);
        tick();
        fifo_input_ready = 1'b1;
        #1;
        chk("stall_keep_last", 48'(req_ready), 48'h1);
        req_valid = 4'h0;

        // Drain two triplets, then flush the 2-word residue through one pad.
        cons_ready = 1'b1;
        #1;
        chk("drain_out_ready", 48'(fifo_output_ready), 48'h1);
        tick();
        chk("drain_occ5", 48'(occupancy), 48'd5);
        chk("drain_trip1", last_trip, {16'h3333, 16'h2222, 16'h1111});
        tick();
        chk("drain_occ2", 48'(occupancy), 48'd2);
        chk("drain_trip2", last_trip, {16'h2222, 16'h1111, 16'h4444});
        chk("residue_no_valid", 48'(cons_valid), 48'h0);
        flush_in = 1'b1;
        p0 = pulses;
        tick();
        flush_in = 1'b0;
        tick();
        chk("pad1_in_valid", 48'(fifo_input_valid), 48'h1);
        chk("pad1_din", 48'(fifo_din), 48'h0);
        tick();
        chk("pad1_occ3", 48'(occupancy), 48'd3);
        tick();
        chk("pad1_trip", last_trip, {16'h0000, 16'h4444, 16'h3333});
        tick();
        chk("flush1_done", 48'(flush_done), 48'h1);
        tick();
        chk("flush1_pulses", 48'(pulses - p0), 48'd1);

        // Single triplet from requester 1.
        req_valid   = 4'b0010;
        req_data[1] = 16'h000A;
        #1;
        chk("st_ready", 48'(req_ready), 48'b0010);
        tick();
        req_data[1] = 16'h000B;
        chk("st_occ1", 48'(occupancy), 48'd1);
        tick();
        req_data[1] = 16'h000C;
        #1;
        chk("st_no_valid_yet", 48'(cons_valid), 48'h0);
        tick();
        req_valid = 4'h0;
        #1;
        chk("st_cons_valid", 48'(cons_valid), 48'h1);
        chk("st_out_ready", 48'(fifo_output_ready), 48'h1);
        tick();
        chk("st_trip", last_trip, {16'h000C, 16'h000B, 16'h000A});
        chk("st_occ0", 48'(occupancy), 48'd0);

        // Full: fill to DEPTH, then read, then read+write together.
        cons_ready = 1'b0;
        req_valid  = 4'b0001;
        for (int i = 0; i < 128; i++) begin
            req_data[0] = 16'(i);
            tick();
        end
        #1;
        chk("full_occ", 48'(occupancy), 48'd128);
        chk("full_no_ready", 48'(req_ready), 48'h0);
        chk("full_cons_valid", 48'(cons_valid), 48'h1);
        req_valid   = 4'h0;
        req_data[0] = 16'h0080;
        cons_ready  = 1'b1;
        tick();
        chk("full_read_occ", 48'(occupancy), 48'd125);
        req_valid = 4'b0001;
        #1;
        chk("simul_ready", 48'(req_ready), 48'h1);
        chk("simul_out_ready", 48'(fifo_output_ready), 48'h1);
        tick();
        chk("simul_occ", 48'(occupancy), 48'd123);
        req_valid = 4'h0;
        for (int i = 0; i < 41; i++) tick();
        chk("full_drained", 48'(occupancy), 48'd0);
        chk("full_last_trip", last_trip, {16'h0080, 16'h007F, 16'h007E});

        // Flush with residue: 5 words, read in the flush cycle, pad one, read, done.
        cons_ready = 1'b0;
        req_valid  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_data[0] = 16'h0011 + 16'(i);
            tick();
        end
        req_valid  = 4'h0;
        cons_ready = 1'b1;
        flush_in   = 1'b1;
        p0 = pulses;
        #1;
        chk("fr_out_ready", 48'(fifo_output_ready), 48'h1);
        tick();
        flush_in  = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("fr_occ2", 48'(occupancy), 48'd2);
        chk("fr_drain_blocked", 48'(req_ready), 48'h0);
        tick();
        chk("fr_pad_valid", 48'(fifo_input_valid), 48'h1);
        chk("fr_pad_din", 48'(fifo_din), 48'h0);
        chk("fr_pad_blocked", 48'(req_ready), 48'h0);
        tick();
        chk("fr_occ3", 48'(occupancy), 48'd3);
        chk("fr_read2", 48'(fifo_output_ready), 48'h1);
        tick();
        chk("fr_occ0", 48'(occupancy), 48'd0);
        chk("fr_trip", last_trip, {16'h0000, 16'h0015, 16'h0014});
        chk("fr_not_done_yet", 48'(flush_done), 48'h0);
        tick();
        chk("fr_done", 48'(flush_done), 48'h1);
        tick();
        chk("fr_done_once", 48'(pulses - p0), 48'd1);
        chk("fr_run_grant", 48'(req_ready), 48'b0010);
        tick();
        req_valid = 4'h0;
        chk("fr_run_occ", 48'(occupancy), 48'd1);

        // Reset while padding: back to RUN, empty, no done pulse.
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        tick();
        chk("rp_in_pad", 48'(fifo_input_valid), 48'h1);
        rst_in = 1'b1;
        p0 = pulses;
        tick();
        chk("rp_occ0", 48'(occupancy), 48'd0);
        rst_in    = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("rp_run_grant0", 48'(req_ready), 48'h1);
        req_valid = 4'h0;
        tick();
        tick();
        chk("rp_no_done", 48'(pulses - p0), 48'd0);
        chk("rp_occ_stays0", 48'(occupancy), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
